// File: rtl/mul8x8_rr_sched.sv
// Round-robin scheduler sharing one combinational 8x8 Dadda multiplier among NREQ requesters.
// Define MUL8X8_RR_SCHED_BYPASS_EN to feed the multiplier straight from the winner (1-cycle latency).
module mul8x8_rr_sched #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_p,
    output logic              busy
);

`ifdef MUL8X8_RR_SCHED_BYPASS_EN
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
`endif

    // Dadda column compression (targets 6,4,3,2) followed by one final carry-propagate add.
    // Columns are bit bags: inputs are consumed from bit 0, new bits are shifted in at bit 0.
    function automatic logic [15:0] mul8x8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] cur [16];
        logic [15:0] nxt [16];
        int          h   [16];
        int          nh  [16];
        int          d;
        logic [3:0]  cc;
        logic [3:0]  cn;
        logic        s;
        logic        co;
        logic [15:0] r0;
        logic [15:0] r1;
        for (int c = 0; c < 16; c++) begin
            cur[4'(c)] = '0;
            h[4'(c)]   = 0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cc      = 4'(i + j);
                cur[cc] = {cur[cc][14:0], a[3'(i)] & b[3'(j)]};
                h[cc]++;
            end
        end
        for (int st = 0; st < 4; st++) begin
            d = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
            for (int c = 0; c < 16; c++) begin
                nxt[4'(c)] = '0;
                nh[4'(c)]  = 0;
            end
            for (int c = 0; c < 16; c++) begin
                cc = 4'(c);
                cn = 4'(c + 1);
                // Carries already pushed into this column count toward its target height.
                for (int r = 0; r < 8; r++) begin
                    if (h[cc] + nh[cc] > d && h[cc] >= 2) begin
                        if (h[cc] + nh[cc] - d >= 2 && h[cc] >= 3) begin
                            s       = ^cur[cc][2:0];
                            co      = (cur[cc][0] & cur[cc][1]) | (cur[cc][2] & (cur[cc][0] ^ cur[cc][1]));
                            cur[cc] = cur[cc] >> 3;
                            h[cc]   -= 3;
                        end else begin
                            s       = cur[cc][0] ^ cur[cc][1];
                            co      = cur[cc][0] & cur[cc][1];
                            cur[cc] = cur[cc] >> 2;
                            h[cc]   -= 2;
                        end
                        nxt[cc] = {nxt[cc][14:0], s};
                        nh[cc]++;
                        if (c < 15) begin
                            nxt[cn] = {nxt[cn][14:0], co};
                            nh[cn]++;
                        end
                    end
                end
                nxt[cc] = (nxt[cc] << h[cc]) | cur[cc];
                nh[cc]  += h[cc];
            end
            cur = nxt;
            h   = nh;
        end
        for (int c = 0; c < 16; c++) begin
            r0[4'(c)] = cur[4'(c)][0];
            r1[4'(c)] = cur[4'(c)][1];
        end
        return r0 + r1;
    endfunction

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           any_valid;
    logic           accept;
    logic [7:0]     a_arr [NREQ];
    logic [7:0]     b_arr [NREQ];
    logic [7:0]     mul_a;
    logic [7:0]     mul_b;
    logic [15:0]    mul_p;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[8*g +: 8];
        assign b_arr[g] = req_b[8*g +: 8];
    end

    // Walk offsets from far to near so the valid requester closest to rr_ptr is kept last.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            cand = IDW'((int'(rr_ptr) + o) % NREQ);
            if (req_valid[cand]) begin
                win       = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: if (any_valid) begin
                req_ready[win] = 1'b1;
`ifdef MUL8X8_RR_SCHED_BYPASS_EN
                state_nxt = HOLD;
`else
                state_nxt = CALC;
`endif
            end
`ifndef MUL8X8_RR_SCHED_BYPASS_EN
            CALC: state_nxt = HOLD;
`endif
            HOLD: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && any_valid;
    assign busy   = (state != IDLE);
    assign mul_p  = mul8x8(mul_a, mul_b);

`ifdef MUL8X8_RR_SCHED_BYPASS_EN
    assign mul_a = a_arr[win];
    assign mul_b = b_arr[win];
`else
    logic [7:0]     op_a;
    logic [7:0]     op_b;
    logic [IDW-1:0] id_q;
    assign mul_a = op_a;
    assign mul_b = op_b;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
`ifndef MUL8X8_RR_SCHED_BYPASS_EN
            op_a      <= '0;
            op_b      <= '0;
            id_q      <= '0;
`endif
        end else begin
            if (accept) begin
                rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
`ifdef MUL8X8_RR_SCHED_BYPASS_EN
                rsp_p     <= mul_p;
                rsp_id    <= win;
                rsp_valid <= 1'b1;
`else
                op_a <= a_arr[win];
                op_b <= b_arr[win];
                id_q <= win;
`endif
            end
`ifndef MUL8X8_RR_SCHED_BYPASS_EN
            if (state == CALC) begin
                rsp_p     <= mul_p;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
`endif
            if (state == HOLD && rsp_ready) rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul8x8_rr_sched.sv
// Directed + random bench for mul8x8_rr_sched with a cycle model and a product scoreboard.
// Honours MUL8X8_RR_SCHED_BYPASS_EN for the expected latency.
module tb_mul8x8_rr_sched;
    localparam int NREQ = 4;
`ifdef MUL8X8_RR_SCHED_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef enum int {PH_IDLE, PH_CALC, PH_HOLD} phase_t;
    typedef struct {
        int          id;
        logic [15:0] p;
    } exp_t;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [31:0]     req_a     = '0;
    logic [31:0]     req_b     = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_p;
    logic            busy;

    exp_t   sb[$];
    phase_t m_phase = PH_IDLE;
    int     m_ptr   = 0;
    int     last_w  = -1;
    int     n_vec   = 0;
    int     n_err   = 0;

    mul8x8_rr_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_ptr   = 0;
        last_w  = -1;
        sb.delete();
    endtask

    // Called at posedge+1; samples at posedge+2, advances the model, returns at next posedge+1.
    task automatic step();
        logic [NREQ-1:0] exp_ready;
        int              w;
        exp_t            e;
        #1;
        exp_ready = '0;
        w         = -1;
        if (m_phase == PH_IDLE)
            for (int o = 0; o < NREQ; o++)
                if (w < 0 && req_valid[(m_ptr + o) % NREQ]) w = (m_ptr + o) % NREQ;
        if (w >= 0) exp_ready[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_phase != PH_IDLE));
        check("rsp_valid", 32'(rsp_valid), 32'(m_phase == PH_HOLD));
        if (m_phase == PH_HOLD) begin
            check("rsp_p", 32'(rsp_p), 32'(sb[0].p));
            check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        end
        last_w = w;
        case (m_phase)
            PH_IDLE: if (w >= 0) begin
                e.id = w;
                e.p  = 16'(req_a[8*w +: 8]) * 16'(req_b[8*w +: 8]);
                sb.push_back(e);
                m_ptr   = (w + 1) % NREQ;
                m_phase = (LAT == 1) ? PH_HOLD : PH_CALC;
            end
            PH_CALC: m_phase = PH_HOLD;
            PH_HOLD: if (rsp_ready) begin
                void'(sb.pop_front());
                m_phase = PH_IDLE;
            end
            default: m_phase = PH_IDLE;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int port, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p);
        int n;
        req_a[8*port +: 8] = a;
        req_b[8*port +: 8] = b;
        req_valid[port]    = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (last_w != port && n < 16);
        check("op_grant", 32'(last_w), 32'(port));
        req_valid[port] = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("op_latency", 32'(n + 1), 32'(LAT));
        check("op_product", 32'(rsp_p), 32'(exp_p));
        check("op_id", 32'(rsp_id), 32'(port));
        step();
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (m_phase != PH_IDLE && n < 8) begin
            step();
            n++;
        end
        check("drain_idle", 32'(m_phase == PH_IDLE), 32'(1));
    endtask

    initial begin
        int n;
        int ng;
        int grants [5];
        int gcyc   [5];

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_rsp_p", 32'(rsp_p), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));

        rsp_ready = 1'b1;
        run_op(0, 8'h0C, 8'h0A, 16'h0078);
        run_op(2, 8'hFF, 8'hFF, 16'hFE01);
        run_op(2, 8'h00, 8'hA5, 16'h0000);
        run_op(2, 8'h80, 8'h02, 16'h0100);

        // All four requesting continuously from a fresh pointer.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        req_a     = 32'h0D0C0B0A;
        req_b     = 32'h11223344;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            grants[k] = -1;
            gcyc[k]   = -100;
        end
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            step();
            if (last_w >= 0) begin
                grants[ng] = last_w;
                gcyc[ng]   = c;
                ng++;
            end
        end
        check("grant_count", 32'(ng), 32'(5));
        for (int k = 0; k < 5; k++) begin
            check("grant_order", 32'(grants[k]), 32'(k % NREQ));
            if (k > 0) check("grant_gap", 32'(gcyc[k] - gcyc[k-1]), 32'(LAT + 1));
        end
        drain();

        // Back-pressure on the response port with other requesters waiting.
        rsp_ready = 1'b0;
        req_a[15:0] = 16'h2133;
        req_b[15:0] = 16'h0705;
        req_valid   = 4'b0011;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            step();
            if (last_w >= 0) req_valid[last_w] = 1'b0;
            n++;
        end
        req_valid = 4'b0011;
        repeat (5) begin
            step();
            check("hold_no_grant", 32'(last_w), 32'(-1));
        end
        rsp_ready = 1'b1;
        step();
        check("handshake_no_grant", 32'(last_w), 32'(-1));
        step();
        check("regrant", 32'(last_w >= 0), 32'(1));
        drain();

        // Reset while a product is held.
        rsp_ready = 1'b0;
        req_a[15:8] = 8'h14;
        req_b[15:8] = 8'hE9;
        req_valid[1] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (last_w != 1 && n < 16);
        req_valid[1] = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("pre_rst_p", 32'(rsp_p), 32'h1234);
        check("pre_rst_id", 32'(rsp_id), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_rsp_p", 32'(rsp_p), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        req_valid = 4'hF;
        step();
        check("post_rst_winner", 32'(last_w), 32'(0));
        drain();

        // Random traffic: requesters hold data until accepted, may withdraw, random back-pressure.
        for (int cy = 0; cy < 20000; cy++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i]    = 1'b1;
                    req_a[8*i +: 8] = 8'($urandom);
                    req_b[8*i +: 8] = 8'($urandom);
                end else if (req_valid[i] && $urandom_range(31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 1'($urandom_range(1));
            step();
            if (last_w >= 0) req_valid[last_w] = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
